// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : MIPS write-back stage. Aligns load data, writes the regfile once
//            per instruction, drives the ID bypass, debug trace and instret.
// Revision : 1.0  initial release
// ============================================================================
module wb_stage #(
    parameter int          BUS_W    = 76,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic [BUS_W-1:0] mem_to_wb_bus,
    input  logic [31:0]      data_sram_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [37:0]      wb_to_id_bus,
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_wen,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata,
    output logic [31:0]      instret
);

    localparam logic [2:0] c_LD_NONE = 3'b000;
    localparam logic [2:0] c_LD_LB   = 3'b001;
    localparam logic [2:0] c_LD_LBU  = 3'b010;
    localparam logic [2:0] c_LD_LH   = 3'b011;
    localparam logic [2:0] c_LD_LHU  = 3'b100;
    localparam logic [2:0] c_LD_LW   = 3'b101;

    logic        r_valid;
    logic        r_done;
    logic [31:0] r_pc;
    logic [2:0]  r_ld_op;
    logic [1:0]  r_byte_off;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_result;
    logic [31:0] r_rdata;
    logic [31:0] r_instret;

    logic        w_retire;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_wdata;

    // One retirement per instruction: done suppresses recounting while held.
    assign w_retire = r_valid & ~r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_pc       <= RESET_PC;
            r_ld_op    <= 3'b000;
            r_byte_off <= 2'b00;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_result   <= 32'd0;
            r_rdata    <= 32'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_pc    <= RESET_PC;
        end else if (stall) begin
            if (w_retire) begin
                r_done <= 1'b1;
            end
        end else begin
            r_valid    <= mem_to_wb_bus[75];
            r_pc       <= mem_to_wb_bus[74:43];
            r_ld_op    <= mem_to_wb_bus[42:40];
            r_byte_off <= mem_to_wb_bus[39:38];
            r_rf_we    <= mem_to_wb_bus[37];
            r_rf_waddr <= mem_to_wb_bus[36:32];
            r_result   <= mem_to_wb_bus[31:0];
            r_rdata    <= data_sram_rdata;
            r_done     <= 1'b0;
        end
    end

    // Counted independently of flush/stall so a flushed retirement is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    always_comb begin
        w_byte = r_rdata[7:0];
        case (r_byte_off)
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_byte_off[1] ? r_rdata[31:16] : r_rdata[15:0];
    end

    always_comb begin
        w_wdata = r_result;
        case (r_ld_op)
            c_LD_NONE: w_wdata = r_result;
            c_LD_LB:   w_wdata = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU:  w_wdata = {24'd0, w_byte};
            c_LD_LH:   w_wdata = {{16{w_half[15]}}, w_half};
            c_LD_LHU:  w_wdata = {16'd0, w_half};
            c_LD_LW:   w_wdata = r_rdata;
            default:   w_wdata = r_result;
        endcase
    end

    assign rf_we             = r_valid & r_rf_we & ~r_done;
    assign rf_waddr          = r_rf_waddr;
    assign rf_wdata          = w_wdata;
    assign wb_to_id_bus      = {r_valid & r_rf_we, r_rf_waddr, w_wdata};
    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = r_rf_waddr;
    assign debug_wb_rf_wdata = w_wdata;
    assign instret           = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Brief    : Directed self-checking bench for wb_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_stage;

    localparam logic [31:0] c_RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [75:0] mem_to_wb_bus;
    logic [31:0] data_sram_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [37:0] wb_to_id_bus;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic [31:0] instret;

    int n_checks = 0;
    int n_pass   = 0;

    wb_stage #(
        .BUS_W    (76),
        .RESET_PC (c_RESET_PC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .data_sram_rdata   (data_sram_rdata),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .wb_to_id_bus      (wb_to_id_bus),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .instret           (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [75:0] mk(input logic v, input logic [31:0] pc,
                                       input logic [2:0] op, input logic [1:0] off,
                                       input logic we, input logic [4:0] wa,
                                       input logic [31:0] res);
        return {v, pc, op, off, we, wa, res};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rf_we"}, {63'd0, rf_we}, 64'd0);
        check({tag, "_rf_waddr"}, {59'd0, rf_waddr}, 64'd0);
        check({tag, "_rf_wdata"}, {32'd0, rf_wdata}, 64'd0);
        check({tag, "_id_bus"}, {26'd0, wb_to_id_bus}, 64'd0);
        check({tag, "_dbg_pc"}, {32'd0, debug_wb_pc}, {32'd0, c_RESET_PC});
        check({tag, "_dbg_wen"}, {60'd0, debug_wb_rf_wen}, 64'd0);
        check({tag, "_dbg_wnum"}, {59'd0, debug_wb_rf_wnum}, 64'd0);
        check({tag, "_dbg_wdata"}, {32'd0, debug_wb_rf_wdata}, 64'd0);
        check({tag, "_instret"}, {32'd0, instret}, 64'd0);
    endtask

    initial begin
        rst             = 1'b0;
        stall           = 1'b0;
        flush           = 1'b0;
        mem_to_wb_bus   = '0;
        data_sram_rdata = '0;

        // Power-on reset
        #2 rst = 1'b1;
        #1;
        check_all_zero("por");
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("idle_instret", {32'd0, instret}, 64'd0);

        // ALU result write
        mem_to_wb_bus = mk(1'b1, 32'h0000_0100, 3'b000, 2'd0, 1'b1, 5'd8, 32'h1234_5678);
        tick();
        check("alu_rf_we", {63'd0, rf_we}, 64'd1);
        check("alu_wdata", {32'd0, rf_wdata}, 64'h1234_5678);
        check("alu_id_bus", {26'd0, wb_to_id_bus}, {26'd0, 1'b1, 5'd8, 32'h1234_5678});
        check("alu_dbg_pc", {32'd0, debug_wb_pc}, 64'h100);
        check("alu_dbg_wen", {60'd0, debug_wb_rf_wen}, 64'hF);
        check("alu_dbg_wnum", {59'd0, debug_wb_rf_wnum}, 64'd8);
        check("alu_instret_pre", {32'd0, instret}, 64'd0);
        mem_to_wb_bus = '0;
        tick();
        check("alu_instret_post", {32'd0, instret}, 64'd1);
        check("alu_rf_we_off", {63'd0, rf_we}, 64'd0);

        // Load alignment / extension
        data_sram_rdata = 32'h80FF_7F01;
        mem_to_wb_bus = mk(1'b1, 32'h104, 3'b001, 2'd3, 1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        check("lb_off3", {32'd0, rf_wdata}, 64'hFFFF_FF80);
        mem_to_wb_bus = mk(1'b1, 32'h108, 3'b010, 2'd1, 1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        check("lbu_off1", {32'd0, rf_wdata}, 64'h0000_007F);
        mem_to_wb_bus = mk(1'b1, 32'h10C, 3'b011, 2'd2, 1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        check("lh_off2", {32'd0, rf_wdata}, 64'hFFFF_80FF);
        mem_to_wb_bus = mk(1'b1, 32'h110, 3'b100, 2'd0, 1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        check("lhu_off0", {32'd0, rf_wdata}, 64'h0000_7F01);
        mem_to_wb_bus = mk(1'b1, 32'h114, 3'b101, 2'd0, 1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        check("lw", {32'd0, rf_wdata}, 64'h80FF_7F01);
        mem_to_wb_bus = mk(1'b1, 32'h118, 3'b110, 2'd1, 1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        check("ldop110_result", {32'd0, rf_wdata}, 64'hDEAD_BEEF);
        mem_to_wb_bus = mk(1'b1, 32'h11C, 3'b001, 2'd0, 1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        check("lb_off0", {32'd0, rf_wdata}, 64'h0000_0001);
        mem_to_wb_bus = mk(1'b1, 32'h120, 3'b011, 2'd1, 1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        check("lh_off1_low", {32'd0, rf_wdata}, 64'h0000_7F01);
        mem_to_wb_bus = '0;
        tick();
        check("loads_instret", {32'd0, instret}, 64'd9);

        // Invalid bus with rf_we set
        mem_to_wb_bus = mk(1'b0, 32'h200, 3'b000, 2'd0, 1'b1, 5'd7, 32'h7777_7777);
        tick();
        check("inv_rf_we", {63'd0, rf_we}, 64'd0);
        check("inv_id_we", {63'd0, wb_to_id_bus[37]}, 64'd0);
        tick();
        check("inv_instret", {32'd0, instret}, 64'd9);

        // Stall: write once, bypass held
        mem_to_wb_bus = mk(1'b1, 32'h300, 3'b000, 2'd0, 1'b1, 5'd3, 32'hAAAA_5555);
        tick();
        check("st0_rf_we", {63'd0, rf_we}, 64'd1);
        check("st0_id_we", {63'd0, wb_to_id_bus[37]}, 64'd1);
        stall = 1'b1;
        mem_to_wb_bus = '0;
        tick();
        check("st1_rf_we", {63'd0, rf_we}, 64'd0);
        check("st1_id_we", {63'd0, wb_to_id_bus[37]}, 64'd1);
        check("st1_instret", {32'd0, instret}, 64'd10);
        tick();
        check("st2_rf_we", {63'd0, rf_we}, 64'd0);
        check("st2_id_bus", {26'd0, wb_to_id_bus}, {26'd0, 1'b1, 5'd3, 32'hAAAA_5555});
        tick();
        check("st3_rf_we", {63'd0, rf_we}, 64'd0);
        check("st3_id_we", {63'd0, wb_to_id_bus[37]}, 64'd1);
        check("st3_instret", {32'd0, instret}, 64'd10);
        stall = 1'b0;
        tick();
        check("st_end_instret", {32'd0, instret}, 64'd10);

        // Flush with stall on an already-retired instruction
        mem_to_wb_bus = mk(1'b1, 32'h400, 3'b000, 2'd0, 1'b1, 5'd4, 32'h0000_0044);
        tick();
        stall = 1'b1;
        mem_to_wb_bus = '0;
        tick();
        check("fl_pre_instret", {32'd0, instret}, 64'd11);
        flush = 1'b1;
        tick();
        check("fl_rf_we", {63'd0, rf_we}, 64'd0);
        check("fl_id_we", {63'd0, wb_to_id_bus[37]}, 64'd0);
        check("fl_dbg_pc", {32'd0, debug_wb_pc}, {32'd0, c_RESET_PC});
        check("fl_instret", {32'd0, instret}, 64'd11);

        // Flush with stall on a not-yet-retired instruction still counts it
        flush = 1'b0;
        stall = 1'b0;
        mem_to_wb_bus = mk(1'b1, 32'h410, 3'b000, 2'd0, 1'b1, 5'd4, 32'h0000_0045);
        tick();
        mem_to_wb_bus = '0;
        flush = 1'b1;
        stall = 1'b1;
        tick();
        check("fl2_instret", {32'd0, instret}, 64'd12);
        check("fl2_rf_we", {63'd0, rf_we}, 64'd0);
        flush = 1'b0;
        stall = 1'b0;
        tick();
        check("fl2_idle_instret", {32'd0, instret}, 64'd12);

        // instret wrap
        mem_to_wb_bus = mk(1'b1, 32'h500, 3'b000, 2'd0, 1'b1, 5'd5, 32'h0000_0001);
        tick();
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        #1;
        check("wrap_pre", {32'd0, instret}, 64'hFFFF_FFFF);
        mem_to_wb_bus = '0;
        tick();
        check("wrap_post", {32'd0, instret}, 64'd0);

        // Asynchronous reset mid-run
        mem_to_wb_bus = mk(1'b1, 32'h600, 3'b101, 2'd0, 1'b1, 5'd6, 32'h0000_0006);
        tick();
        check("mid_rf_we", {63'd0, rf_we}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async");
        mem_to_wb_bus = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_instret", {32'd0, instret}, 64'd0);
        check("post_rst_rf_we", {63'd0, rf_we}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
